game_status_scan: RTL and testbench

Board status scanner downstream of the defuse flood-fill stage. It walks every field of the active board once per scan pass, one field per clock. For each pass it counts mines and safely defused fields, detects a defused mine, and latches sticky win/lose flags. The game FSM and the HUD drawing stage consume these flags and counts.

---
 rtl/game_status_scan_if.sv | 34 +++
 rtl/game_status_scan.sv | 124 ++++++++++++
 tb/tb_game_status_scan.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/game_status_scan_if.sv
// Bundle between the game logic and the board status scanner: board maps in,
// per-pass counts and sticky win/lose flags out.
interface game_status_scan_if;
    logic                clear;
    logic [1:0]          level;
    logic [7:0][7:0]     mine_arr_easy;
    logic [9:0][9:0]     mine_arr_medium;
    logic [15:0][15:0]   mine_arr_hard;
    logic [7:0][7:0]     defuse_arr_easy;
    logic [9:0][9:0]     defuse_arr_medium;
    logic [15:0][15:0]   defuse_arr_hard;
    logic [8:0]          defused_count;
    logic [8:0]          mine_count;
    logic                game_won;
    logic                game_lost;
    logic                scan_done;

    // No valid/ready here: maps and level are level-sensitive inputs sampled
    // live every cycle; scan_done is a one-cycle strobe meaning the counts and
    // flags were refreshed on the preceding edge and hold until the next one.
    modport master (
        output clear, level,
        output mine_arr_easy, mine_arr_medium, mine_arr_hard,
        output defuse_arr_easy, defuse_arr_medium, defuse_arr_hard,
        input  defused_count, mine_count, game_won, game_lost, scan_done
    );

    modport slave (
        input  clear, level,
        input  mine_arr_easy, mine_arr_medium, mine_arr_hard,
        input  defuse_arr_easy, defuse_arr_medium, defuse_arr_hard,
        output defused_count, mine_count, game_won, game_lost, scan_done
    );
endinterface

// File: rtl/game_status_scan.sv
// Free-running board scanner: one field per clock, counts mines and defused
// safe fields per pass and latches sticky win/lose flags.
module game_status_scan (
    input  logic               clk,
    input  logic               rst,
    game_status_scan_if.slave  bus,
    output logic [1:0]         scan_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        UPDATE = 2'd2
    } state_t;

    state_t     state;
    logic [1:0] level_q;
    logic [3:0] x;
    logic [3:0] y;
    logic [3:0] n_last;
    logic [8:0] nn;
    logic [8:0] mine_acc;
    logic [8:0] safe_acc;
    logic       boom_acc;
    logic       mine_bit;
    logic       defuse_bit;
    logic       restart;

    assign scan_state = state;

    // Any change of level counts as a new game, just like clear.
    assign restart = rst || bus.clear || (bus.level == 2'd0) || (bus.level != level_q);

    always_comb begin
        n_last     = 4'd0;
        nn         = 9'd0;
        mine_bit   = 1'b0;
        defuse_bit = 1'b0;
        case (bus.level)
            2'd1: begin
                n_last     = 4'd7;
                nn         = 9'd64;
                mine_bit   = bus.mine_arr_easy[x[2:0]][y[2:0]];
                defuse_bit = bus.defuse_arr_easy[x[2:0]][y[2:0]];
            end
            2'd2: begin
                n_last     = 4'd9;
                nn         = 9'd100;
                mine_bit   = bus.mine_arr_medium[x][y];
                defuse_bit = bus.defuse_arr_medium[x][y];
            end
            2'd3: begin
                n_last     = 4'd15;
                nn         = 9'd256;
                mine_bit   = bus.mine_arr_hard[x][y];
                defuse_bit = bus.defuse_arr_hard[x][y];
            end
            default: begin
                n_last = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        level_q       <= bus.level;
        bus.scan_done <= 1'b0;
        if (restart) begin
            state             <= IDLE;
            x                 <= 4'd0;
            y                 <= 4'd0;
            mine_acc          <= 9'd0;
            safe_acc          <= 9'd0;
            boom_acc          <= 1'b0;
            bus.defused_count <= 9'd0;
            bus.mine_count    <= 9'd0;
            bus.game_won      <= 1'b0;
            bus.game_lost     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state <= SCAN;
                end
                SCAN: begin
                    mine_acc <= mine_acc + {8'd0, mine_bit};
                    safe_acc <= safe_acc + {8'd0, defuse_bit & ~mine_bit};
                    boom_acc <= boom_acc | (defuse_bit & mine_bit);
                    if (x == n_last) begin
                        x <= 4'd0;
                        if (y == n_last) begin
                            y     <= 4'd0;
                            state <= UPDATE;
                        end else begin
                            y <= y + 4'd1;
                        end
                    end else begin
                        x <= x + 4'd1;
                    end
                end
                UPDATE: begin
                    bus.defused_count <= safe_acc;
                    bus.mine_count    <= mine_acc;
                    // Flags freeze once either is set, so they can never both be high.
                    if (!bus.game_won && !bus.game_lost) begin
                        if (boom_acc)
                            bus.game_lost <= 1'b1;
                        else if (mine_acc != 9'd0 && (safe_acc + mine_acc) == nn)
                            bus.game_won <= 1'b1;
                    end
                    bus.scan_done <= 1'b1;
                    mine_acc      <= 9'd0;
                    safe_acc      <= 9'd0;
                    boom_acc      <= 1'b0;
                    x             <= 4'd0;
                    y             <= 4'd0;
                    state         <= SCAN;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_status_scan.sv
// Directed bench for game_status_scan: a table of board patterns with
// hand-computed counts/flags, then sequences for clear, level change and rst.
module tb_game_status_scan;

    logic       clk;
    logic       rst;
    logic [1:0] scan_state;
    int         checks;
    int         errors;

    game_status_scan_if bus ();

    game_status_scan dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .scan_state (scan_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] level;
        int         pattern;
        int         exp_mines;
        int         exp_defused;
        int         exp_won;
        int         exp_lost;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input int m, input int d, input int w, input int l);
        check({tag, " mine_count"}, int'(bus.mine_count), m);
        check({tag, " defused_count"}, int'(bus.defused_count), d);
        check({tag, " game_won"}, int'(bus.game_won), w);
        check({tag, " game_lost"}, int'(bus.game_lost), l);
    endtask

    // Edges until scan_done is seen, counting the first edge as 1; -1 on timeout.
    task automatic wait_done(input int budget, output int cnt);
        cnt = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (bus.scan_done) begin
                cnt = i;
                break;
            end
        end
    endtask

    task automatic clear_maps();
        bus.mine_arr_easy     = '0;
        bus.mine_arr_medium   = '0;
        bus.mine_arr_hard     = '0;
        bus.defuse_arr_easy   = '0;
        bus.defuse_arr_medium = '0;
        bus.defuse_arr_hard   = '0;
    endtask

    task automatic fill_pattern(input int p);
        case (p)
            0: begin
                bus.mine_arr_easy[0][0] = 1'b1;
                bus.mine_arr_easy[3][4] = 1'b1;
            end
            1: begin
                bus.mine_arr_easy[0][0] = 1'b1;
                bus.mine_arr_easy[3][4] = 1'b1;
                bus.defuse_arr_easy     = ~bus.mine_arr_easy;
            end
            2: begin
                bus.mine_arr_hard[15][15]   = 1'b1;
                bus.defuse_arr_hard[15][15] = 1'b1;
            end
            3: begin
                bus.mine_arr_medium[9][9] = 1'b1;
                bus.mine_arr_medium[0][9] = 1'b1;
                bus.mine_arr_medium[5][5] = 1'b1;
                bus.defuse_arr_medium     = ~bus.mine_arr_medium;
            end
            4: begin
                bus.mine_arr_medium[2][3]   = 1'b1;
                bus.defuse_arr_medium[2][3] = 1'b1;
                bus.defuse_arr_medium[0][0] = 1'b1;
            end
            5: bus.mine_arr_hard = '1;
            6: bus.defuse_arr_easy = '1;
            7: for (int i = 0; i < 16; i++) bus.defuse_arr_hard[i][i] = 1'b1;
            default: clear_maps();
        endcase
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        bus.clear = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    function automatic int cells(input logic [1:0] lv);
        case (lv)
            2'd1:    return 64;
            2'd2:    return 100;
            2'd3:    return 256;
            default: return 0;
        endcase
    endfunction

    initial begin
        int cnt;
        int nonzero;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.clear = 1'b0;
        bus.level = 2'd0;
        clear_maps();

        vecs[0] = '{2'd1, 0, 2,   0,  0, 0};
        vecs[1] = '{2'd1, 1, 2,   62, 1, 0};
        vecs[2] = '{2'd3, 2, 1,   0,  0, 1};
        vecs[3] = '{2'd2, 3, 3,   97, 1, 0};
        vecs[4] = '{2'd2, 4, 1,   1,  0, 1};
        vecs[5] = '{2'd3, 5, 256, 0,  1, 0};
        vecs[6] = '{2'd1, 6, 0,   64, 0, 0};
        vecs[7] = '{2'd3, 7, 0,   16, 0, 0};

        for (int v = 0; v < 8; v++) begin
            clear_maps();
            fill_pattern(vecs[v].pattern);
            bus.level = vecs[v].level;
            rst = 1'b1;
            tick();
            tick();
            check_outputs($sformatf("v%0d reset", v), 0, 0, 0, 0);
            check($sformatf("v%0d reset scan_done", v), int'(bus.scan_done), 0);
            check($sformatf("v%0d reset state", v), int'(scan_state), 0);
            rst = 1'b0;
            // The edge leaving IDLE counts as edge 1 of the first-refresh latency.
            wait_done(400, cnt);
            check($sformatf("v%0d first latency", v), cnt, cells(vecs[v].level) + 2);
            check_outputs($sformatf("v%0d pass1", v), vecs[v].exp_mines, vecs[v].exp_defused,
                          vecs[v].exp_won, vecs[v].exp_lost);
            wait_done(400, cnt);
            check($sformatf("v%0d period", v), cnt, cells(vecs[v].level) + 1);
            check_outputs($sformatf("v%0d pass2", v), vecs[v].exp_mines, vecs[v].exp_defused,
                          vecs[v].exp_won, vecs[v].exp_lost);
        end

        // Win stays latched after the defuse map is wiped.
        clear_maps();
        fill_pattern(1);
        bus.level = 2'd1;
        do_reset();
        wait_done(400, cnt);
        check("sticky first latency", cnt, 66);
        check_outputs("sticky pass1", 2, 62, 1, 0);
        bus.defuse_arr_easy = '0;
        wait_done(400, cnt);
        check("sticky period", cnt, 65);
        check_outputs("sticky pass2", 2, 0, 1, 0);

        // Clear at cell 40 of a medium pass.
        clear_maps();
        fill_pattern(3);
        bus.level = 2'd2;
        do_reset();
        wait_done(400, cnt);
        check_outputs("clr pre", 3, 97, 1, 0);
        for (int i = 0; i < 40; i++) tick();
        bus.clear = 1'b1;
        tick();
        check_outputs("clr edge", 0, 0, 0, 0);
        check("clr edge scan_done", int'(bus.scan_done), 0);
        bus.clear = 1'b0;
        wait_done(400, cnt);
        check("clr restart latency", cnt, 102);
        check_outputs("clr after", 3, 97, 1, 0);

        // Level 1 -> 2 mid-pass restarts with N=10.
        clear_maps();
        fill_pattern(0);
        fill_pattern(3);
        bus.level = 2'd1;
        do_reset();
        wait_done(400, cnt);
        check("lvl easy latency", cnt, 66);
        check_outputs("lvl easy", 2, 0, 0, 0);
        for (int i = 0; i < 20; i++) tick();
        bus.level = 2'd2;
        tick();
        check_outputs("lvl change edge", 0, 0, 0, 0);
        check("lvl change scan_done", int'(bus.scan_done), 0);
        wait_done(400, cnt);
        check("lvl medium latency", cnt, 102);
        check_outputs("lvl medium", 3, 97, 1, 0);
        wait_done(400, cnt);
        check("lvl medium period", cnt, 101);

        // rst while in UPDATE: pass dropped, no strobe.
        for (int i = 0; i < 100; i++) tick();
        check("upd state", int'(scan_state), 2);
        rst = 1'b1;
        tick();
        check("upd rst scan_done", int'(bus.scan_done), 0);
        check_outputs("upd rst", 0, 0, 0, 0);
        rst = 1'b0;
        wait_done(400, cnt);
        check("upd restart latency", cnt, 102);
        check_outputs("upd restart", 3, 97, 1, 0);

        // level 0 holds everything at zero.
        bus.level = 2'd0;
        nonzero = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (bus.scan_done || bus.game_won || bus.game_lost ||
                bus.mine_count != 9'd0 || bus.defused_count != 9'd0)
                nonzero++;
        end
        check("lvl0 nonzero cycles", nonzero, 0);
        check("lvl0 state", int'(scan_state), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
